// File: rtl/mux_sel_seq.sv
// Select sequencer feeding the tgmux16 transmission-gate mux: latches two operands and
// plays a select bit pattern one bit per clock for a programmed number of passes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sel low, operands held
// RUN     | playing pattern bits on sel, counting completed passes
// DONE    | single-cycle completion pulse, then back to IDLE
module mux_sel_seq #(
    parameter int WIDTH   = 8,
    parameter int PAT_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   repeat_num,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic [WIDTH-1:0]   in1,
    output logic [WIDTH-1:0]   in2,
    output logic               sel,
    output logic               sel_edge,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PAT_LEN-1:0] pattern_q;
    logic [CNT_W-1:0]   repeat_q;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   pass_nxt;
    logic               sel_nxt;
    logic               capture;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pass_nxt  = pass_cnt;
        sel_nxt   = sel;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_nxt = 1'b0;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ST_RUN;
                    idx_nxt   = '0;
                    pass_nxt  = '0;
                    sel_nxt   = pattern[PAT_LEN-1];
                end
            end
            ST_RUN: begin
                if (!hold) begin
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        pass_nxt = pass_cnt + 1'b1;
                        // repeat count of zero never terminates; only rst leaves RUN
                        if ((repeat_q != '0) && (pass_nxt == repeat_q)) begin
                            state_nxt = ST_DONE;
                            sel_nxt   = 1'b0;
                        end else begin
                            sel_nxt = pattern_q[PAT_LEN-1];
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                        sel_nxt = pattern_q[IDX_LAST - idx_nxt];
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                sel_nxt   = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                sel_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pattern_q <= '0;
            repeat_q  <= '0;
            idx       <= '0;
            pass_cnt  <= '0;
            sel       <= 1'b0;
            sel_edge  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in1       <= '0;
            in2       <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            pass_cnt <= pass_nxt;
            sel      <= sel_nxt;
            // strobe lands in the same cycle the new sel value appears
            sel_edge <= (sel_nxt != sel);
            busy     <= (state_nxt == ST_RUN);
            done     <= (state_nxt == ST_DONE);
            if (capture) begin
                pattern_q <= pattern;
                repeat_q  <= repeat_num;
                in1       <= data_a;
                in2       <= data_b;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: directed vector table, hand-written corner sequences and
// random traffic compared each cycle against a pass/position reference model.
module tb_mux_sel_seq;

    localparam int WIDTH   = 8;
    localparam int PAT_LEN = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               hold;
    logic [PAT_LEN-1:0] pattern;
    logic [CNT_W-1:0]   repeat_num;
    logic [WIDTH-1:0]   data_a;
    logic [WIDTH-1:0]   data_b;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               sel;
    logic               sel_edge;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pass_cnt;

    mux_sel_seq #(.WIDTH(WIDTH), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .pattern(pattern),
        .repeat_num(repeat_num), .data_a(data_a), .data_b(data_b),
        .in1(in1), .in2(in2), .sel(sel), .sel_edge(sel_edge), .busy(busy),
        .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: mode 0 idle / 1 running / 2 completion cycle; t = bits advanced since start
    int               m_mode = 0;
    int               m_t = 0;
    logic [PAT_LEN-1:0] m_pat = '0;
    logic [CNT_W-1:0] m_rep = '0;
    logic [WIDTH-1:0] m_in1 = '0;
    logic [WIDTH-1:0] m_in2 = '0;
    logic             m_prev_sel = 1'b0;
    logic             e_sel, e_edge, e_busy, e_done;
    logic [CNT_W-1:0] e_pass;

    typedef struct {
        logic             start;
        logic [WIDTH-1:0] a;
        logic             sel;
        logic             edge_v;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] pass;
        logic [WIDTH-1:0] in1;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = 0;
            m_t    = 0;
            m_pat  = '0;
            m_rep  = '0;
            m_in1  = '0;
            m_in2  = '0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1;
                    m_t    = 0;
                    m_pat  = pattern;
                    m_rep  = repeat_num;
                    m_in1  = data_a;
                    m_in2  = data_b;
                end
                1: if (!hold) begin
                    m_t++;
                    if (m_rep != 0 && m_t == int'(m_rep) * PAT_LEN) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
        e_sel  = (m_mode == 1) ? m_pat[PAT_LEN-1 - (m_t % PAT_LEN)] : 1'b0;
        e_edge = rst ? 1'b0 : (e_sel != m_prev_sel);
        m_prev_sel = e_sel;
        e_busy = (m_mode == 1);
        e_done = (m_mode == 2);
        e_pass = CNT_W'((m_t / PAT_LEN) % (1 << CNT_W));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_sel", sel, e_sel);
        chk("m_sel_edge", sel_edge, e_edge);
        chk("m_busy", busy, e_busy);
        chk("m_done", done, e_done);
        chk("m_pass_cnt", pass_cnt, e_pass);
        chk("m_in1", in1, m_in1);
        chk("m_in2", in2, m_in2);
    endtask

    initial begin
        logic [16:0] sel_v;
        logic [16:0] edge_v;
        int          done_cyc;
        bit          seen_255, wrapped, done_seen, busy_drop;

        sel_v  = 17'b01100000011000000;
        edge_v = 17'b10100000101000000;
        for (int c = 1; c <= 17; c++) begin
            tbl[c-1].start  = (c == 1) || (c == 4);
            tbl[c-1].a      = (c == 4) ? 8'h55 : 8'hF0;
            tbl[c-1].sel    = sel_v[c-1];
            tbl[c-1].edge_v = edge_v[c-1];
            tbl[c-1].busy   = (c <= 16);
            tbl[c-1].done   = (c == 17);
            tbl[c-1].pass   = (c <= 8) ? 8'd0 : (c <= 16) ? 8'd1 : 8'd2;
            tbl[c-1].in1    = 8'hF0;
        end
        // start during the DONE cycle is ignored; the one after it is accepted
        tbl[17] = '{start: 1'b1, a: 8'h12, sel: 1'b0, edge_v: 1'b0, busy: 1'b0, done: 1'b0, pass: 8'd2, in1: 8'hF0};
        tbl[18] = '{start: 1'b1, a: 8'h12, sel: 1'b0, edge_v: 1'b0, busy: 1'b1, done: 1'b0, pass: 8'd0, in1: 8'h12};

        rst = 1'b1; start = 1'b1; hold = 1'b0;
        pattern = 8'hFF; repeat_num = 8'd1; data_a = 8'hA5; data_b = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_busy", busy, 0);
            chk("rst_sel", sel, 0);
            chk("rst_in1", in1, 0);
            chk("rst_pass", pass_cnt, 0);
        end
        rst = 1'b0; start = 1'b0;
        step();

        pattern = 8'b00000011; repeat_num = 8'd2; data_b = 8'hCC;
        for (int i = 0; i < 19; i++) begin
            start  = tbl[i].start;
            data_a = tbl[i].a;
            step();
            chk("tbl_sel", sel, tbl[i].sel);
            chk("tbl_sel_edge", sel_edge, tbl[i].edge_v);
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_done", done, tbl[i].done);
            chk("tbl_pass_cnt", pass_cnt, tbl[i].pass);
            chk("tbl_in1", in1, tbl[i].in1);
            chk("tbl_in2", in2, 8'hCC);
        end
        start = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        pattern = 8'hAA; repeat_num = 8'd1; data_a = 8'h0F; data_b = 8'hF0;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cyc = 0;
        for (int c = 2; c <= 20; c++) begin
            hold = (c >= 4 && c <= 6);
            step();
            if (c >= 3 && c <= 6) chk("hold_sel_frozen", sel, 1);
            if (c >= 4 && c <= 6) chk("hold_no_edge", sel_edge, 0);
            if (done && done_cyc == 0) done_cyc = c;
        end
        hold = 1'b0;
        chk("hold_done_cycle", done_cyc, 12);

        pattern = 8'b00000011; repeat_num = 8'd3; data_a = 8'h33; data_b = 8'h44;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_in1", in1, 0);
        chk("mid_rst_pass", pass_cnt, 0);
        step();
        chk("mid_rst_no_done", done, 0);

        pattern = 8'h80; repeat_num = 8'd0; data_a = 8'h11; data_b = 8'h22;
        start = 1'b1;
        step();
        start = 1'b0;
        seen_255 = 0; wrapped = 0; done_seen = 0; busy_drop = 0;
        for (int i = 0; i < 300 * PAT_LEN; i++) begin
            step();
            if (pass_cnt == 8'd255) seen_255 = 1;
            if (seen_255 && pass_cnt == 8'd0) wrapped = 1;
            if (done) done_seen = 1;
            if (!busy) busy_drop = 1;
        end
        chk("cont_wrap", wrapped, 1);
        chk("cont_no_done", done_seen, 0);
        chk("cont_busy_held", busy_drop, 0);
        chk("cont_pass_300", pass_cnt, 300 % 256);
        rst = 1'b1;
        step();
        rst = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 3) == 0);
            hold       = ($urandom_range(0, 4) == 0);
            pattern    = PAT_LEN'($urandom);
            repeat_num = CNT_W'($urandom_range(0, 3));
            data_a     = WIDTH'($urandom);
            data_b     = WIDTH'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_sel_seq.md
# mux_sel_seq

Synchronous select sequencer that sits directly upstream of the `tgmux16` 8-bit transmission-gate mux in the digital-neuron datapath. On a start request it snapshots two operand words onto the mux `in1`/`in2` inputs and plays out a programmable select bit pattern on `sel`, one bit per clock, for a programmed number of passes. It also emits a one-cycle strobe on every select edge, so delay and power measurement triggers can be aligned to real mux switching events.

## Interface
Parameters:
- `WIDTH`, 8, operand word width; matches the mux data width.
- `PAT_LEN`, 8, number of select bits in one pattern pass.
- `CNT_W`, 8, width of the pass counter and of `repeat_num`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to begin a sequence; sampled only in IDLE.
- `hold`  in  1  freezes the sequence in RUN; all outputs keep their current values.
- `pattern`  in  PAT_LEN  select pattern; MSB is played first. Captured at start.
- `repeat_num`  in  CNT_W  number of passes; 0 means run continuously. Captured at start.
- `data_a`  in  WIDTH  operand routed to mux `in1`. Captured at start.
- `data_b`  in  WIDTH  operand routed to mux `in2`. Captured at start.
- `in1`  out  WIDTH  registered operand 1, drives the mux.
- `in2`  out  WIDTH  registered operand 2, drives the mux.
- `sel`  out  1  registered mux select.
- `sel_edge`  out  1  one-cycle pulse in the first cycle that `sel` holds a new value.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the final pass completes.
- `pass_cnt`  out  CNT_W  number of completed passes; wraps modulo 2^CNT_W in continuous mode.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `sel`=0, `busy`=0, `done`=0.
  - `start`=1 → capture `pattern`, `repeat_num`, `data_a`→`in1`, `data_b`→`in2`; clear the bit index and `pass_cnt`; go to RUN.
- RUN:
  - `sel` = `pattern_q[PAT_LEN-1-idx]`; `idx` advances each cycle while `hold`=0.
  - When `idx` reaches PAT_LEN-1 and advances:
    - `idx` wraps to 0 and `pass_cnt` increments.
    - If `repeat_num_q`≠0 and the new `pass_cnt` equals `repeat_num_q` → go to DONE. Otherwise start the next pass.
- DONE:
  - Lasts exactly one cycle: `done`=1, `busy`=0, `sel`=0.
  - Always returns to IDLE. `start` is ignored in this cycle.
- `start` in RUN or DONE is ignored. A new sequence requires IDLE.
- `in1`/`in2` change only on an accepted start and hold their value through IDLE, RUN and DONE.
- `sel_edge` = 1 in any cycle where the registered `sel` differs from its value in the previous cycle. This includes the 1→0 drop on entering DONE.
- `hold`=1 in RUN freezes `idx`, `pass_cnt` and `sel`; `sel_edge`=0 during hold. `hold` has no effect in IDLE or DONE.
- `rst`=1 at any point, including mid-RUN:
  - Next state is IDLE.
  - `in1`=`in2`=0, `sel`=0, `sel_edge`=0, `busy`=0, `done`=0, `pass_cnt`=0. All captured registers are cleared.
- Continuous mode (`repeat_num`=0) leaves RUN only through `rst`.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Start latency: `start` sampled at edge N → `busy`=1, `sel`=`pattern[PAT_LEN-1]`, and `in1`/`in2` valid after edge N.
- With `hold`=0, a run of R passes keeps `busy`=1 for exactly R·PAT_LEN cycles, followed by one `done` cycle.
- Earliest restart: `start` asserted in the cycle after DONE (back in IDLE) is accepted.
- `sel_edge` is coincident with the `sel` transition it reports, not delayed.

## Test plan
- Reset: hold `rst`=1 for 3 cycles, with `start`=1 throughout. → All outputs 0 and no transition to RUN.
- Basic run: `pattern`=8'b00000011, `repeat_num`=2, `data_a`=8'hF0, `data_b`=8'hCC, pulse `start`.
  - `in1`=F0 and `in2`=CC from cycle 1.
  - `sel` sequence is 0,0,0,0,0,0,1,1,0,0,0,0,0,0,1,1, then `done`=1 in cycle 17.
  - `sel_edge` pulses in cycles 7, 9, 15 and 17.
  - `busy` is high for 16 cycles; `pass_cnt` ends at 2.
- Hold: `pattern`=8'hAA, `repeat_num`=1, `hold`=1 for 3 cycles starting in cycle 3.
  - `sel` stays frozen at 1 with no `sel_edge` during the hold.
  - `done` arrives 3 cycles late, in cycle 12.
- Ignored start: assert `start` mid-RUN with new `data_a`=8'h55. → `in1` stays F0 and the sequence is unchanged.
- Reset mid-operation: assert `rst` in cycle 5 of a run. → One cycle later the block is in IDLE with all outputs 0 and no `done` pulse.
- Continuous mode: `repeat_num`=0, `pattern`=8'h80, run for 300 passes.
  - `pass_cnt` wraps 255→0.
  - `done` never asserts and `busy` stays 1.
